// File: rtl/stecker_pkg.sv
// Shared types for the programmable plugboard: letter/one-hot types, the
// partner-index map, the load FSM states and an identity-map helper.
package stecker_pkg;

  localparam int LETTERS = 26;

  typedef logic [4:0]         letter_t;
  typedef logic [LETTERS-1:0] onehot_t;
  typedef letter_t [LETTERS-1:0] map_t;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  function automatic map_t identityMap();
    map_t m;
    for (int i = 0; i < LETTERS; i++) begin
      m[i] = letter_t'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/stecker_perm.sv
// Combinational letter permutation: input bit i lands on output bit map_i[i].
// Works for any one-hot or multi-hot vector; shared with the rotor return path.
module stecker_perm
  import stecker_pkg::*;
(
  input  onehot_t onehot_i,
  input  map_t    map_i,
  output onehot_t onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int j = 0; j < LETTERS; j++) begin
      for (int i = 0; i < LETTERS; i++) begin
        if (map_i[i] == letter_t'(j)) begin
          onehot_o[j] = onehot_o[j] | onehot_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/stecker_prog.sv
// Runtime-programmable plugboard: pairs are loaded into a shadow table over a
// valid/ready interface and committed atomically; lookups are registered.
// Optional macro STECKER_ONEHOT_CHK_EN adds out_bad and zeroes non-one-hot results.
module stecker_prog #(
  parameter int MAX_PAIRS = 10,
  parameter int LETTERS   = stecker_pkg::LETTERS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [4:0]         cfg_a,
  input  logic [4:0]         cfg_b,
  input  logic               cfg_last,
  input  logic               cfg_clear,
  output logic               cfg_done,
  output logic               cfg_err,
  output logic [3:0]         pairs_used,
  input  logic               in_valid,
  input  logic [LETTERS-1:0] in_onehot,
  output logic               out_valid,
  output logic [LETTERS-1:0] out_onehot
`ifdef STECKER_ONEHOT_CHK_EN
  ,
  output logic               out_bad
`endif
);

  import stecker_pkg::*;

  state_t  state_q, state_d;
  map_t    shadow_q, shadow_d;
  map_t    active_q;
  logic [3:0] pairsUsed_q, pairsUsed_d;
  logic    err_q, err_d;
  logic    activeLoad;
  logic    handshake;
  logic    pairOk;
  letter_t aIdx, bIdx;
  onehot_t permuted;
  onehot_t lookup;
  logic    outValid_q;
  onehot_t outOnehot_q;

  assign cfg_ready  = (state_q != COMMIT);
  assign cfg_done   = (state_q == COMMIT) && !err_q;
  assign cfg_err    = err_q;
  assign pairs_used = pairsUsed_q;
  assign out_valid  = outValid_q;
  assign out_onehot = outOnehot_q;
  assign handshake  = cfg_valid && cfg_ready;

  // Out-of-range letters are clamped only for the table read; they still fail the check.
  assign aIdx = (cfg_a < 5'd26) ? cfg_a : '0;
  assign bIdx = (cfg_b < 5'd26) ? cfg_b : '0;
  assign pairOk = (cfg_a < 5'd26) && (cfg_b < 5'd26) && (cfg_a != cfg_b) &&
                  (shadow_q[aIdx] == cfg_a) && (shadow_q[bIdx] == cfg_b) &&
                  (pairsUsed_q != 4'(MAX_PAIRS));

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    pairsUsed_d = pairsUsed_q;
    err_d       = err_q;
    activeLoad  = 1'b0;
    if (state_q == COMMIT) begin
      activeLoad  = !err_q;
      shadow_d    = identityMap();
      pairsUsed_d = '0;
      state_d     = IDLE;
    end else if (cfg_clear) begin
      shadow_d    = identityMap();
      pairsUsed_d = '0;
      err_d       = 1'b0;
      state_d     = IDLE;
    end else if (handshake) begin
      // The first pair of a load starts with a clean error flag.
      err_d = ((state_q == LOAD) ? err_q : 1'b0) | !pairOk;
      if (pairOk) begin
        shadow_d[aIdx] = cfg_b;
        shadow_d[bIdx] = cfg_a;
        pairsUsed_d    = pairsUsed_q + 4'd1;
      end
      state_d = cfg_last ? COMMIT : LOAD;
    end
  end

  stecker_perm uPerm (
    .onehot_i (onehot_t'(in_onehot)),
    .map_i    (active_q),
    .onehot_o (permuted)
  );

`ifdef STECKER_ONEHOT_CHK_EN
  logic isOneHot;
  logic outBad_q;
  assign isOneHot = (in_onehot != '0) && ((in_onehot & (in_onehot - 1'b1)) == '0);
  assign lookup   = isOneHot ? permuted : '0;
  assign out_bad  = outBad_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      outBad_q <= 1'b0;
    end else if (in_valid) begin
      outBad_q <= !isOneHot;
    end
  end
`else
  assign lookup = permuted;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= identityMap();
      active_q    <= identityMap();
      pairsUsed_q <= '0;
      err_q       <= 1'b0;
      outValid_q  <= 1'b0;
      outOnehot_q <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      pairsUsed_q <= pairsUsed_d;
      err_q       <= err_d;
      outValid_q  <= in_valid;
      if (activeLoad) begin
        active_q <= shadow_q;
      end
      if (in_valid) begin
        outOnehot_q <= lookup;
      end
    end
  end

endmodule

// File: tb/tb_stecker_prog.sv
// Scoreboard bench for stecker_prog: directed plugboard scenarios plus random
// loads/lookups against an array-based plugboard model.
module tb_stecker_prog;

  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [4:0]  cfg_a = '0;
  logic [4:0]  cfg_b = '0;
  logic        cfg_last = 1'b0;
  logic        cfg_clear = 1'b0;
  logic        cfg_done;
  logic        cfg_err;
  logic [3:0]  pairs_used;
  logic        in_valid = 1'b0;
  logic [25:0] in_onehot = '0;
  logic        out_valid;
  logic [25:0] out_onehot;
`ifdef STECKER_ONEHOT_CHK_EN
  logic        out_bad;
`endif

  always #5 clk = ~clk;

  stecker_prog #(.MAX_PAIRS(MAXP), .LETTERS(26)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .cfg_last   (cfg_last),
    .cfg_clear  (cfg_clear),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .pairs_used (pairs_used),
    .in_valid   (in_valid),
    .in_onehot  (in_onehot),
    .out_valid  (out_valid),
    .out_onehot (out_onehot)
`ifdef STECKER_ONEHOT_CHK_EN
    ,
    .out_bad    (out_bad)
`endif
  );

  typedef struct packed {
    logic [63:0] due;
    logic [25:0] onehot;
    logic        bad;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp = '0;
  int   checks = 0;
  int   passed = 0;

  // Plugboard model: partner of each letter, plus load bookkeeping (0 idle, 1 loading, 2 commit)
  int   mActive[26];
  int   mShadow[26];
  int   mUsed;
  bit   mErr;
  int   mPhase;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, want, $time);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 26; i++) begin
      mActive[i] = i;
      mShadow[i] = i;
    end
    mUsed  = 0;
    mErr   = 1'b0;
    mPhase = 0;
  endtask

  function automatic exp_t modelLookup(input logic [25:0] v);
    exp_t e;
    e = '0;
    e.due = 64'($time) + 64'd10;
`ifdef STECKER_ONEHOT_CHK_EN
    if ($countones(v) != 1) begin
      e.bad = 1'b1;
      return e;
    end
`endif
    for (int j = 0; j < 26; j++) e.onehot[j] = v[mActive[j]];
    return e;
  endfunction

  // One clock of stimulus: check config outputs, drive inputs, then advance the model.
  task automatic applyStimulus(input bit cv, input int a, input int b, input bit last,
                               input bit clr, input bit iv, input logic [25:0] vec);
    bit ok;
    @(negedge clk);
    checkOutput("cfg_ready", 32'(cfg_ready), 32'(mPhase != 2));
    checkOutput("cfg_done", 32'(cfg_done), 32'(mPhase == 2 && !mErr));
    checkOutput("cfg_err", 32'(cfg_err), 32'(mErr));
    checkOutput("pairs_used", 32'(pairs_used), 32'(mUsed));
    cfg_valid = cv;
    cfg_a     = 5'(a);
    cfg_b     = 5'(b);
    cfg_last  = last;
    cfg_clear = clr;
    in_valid  = iv;
    in_onehot = vec;
    if (iv) expQ.push_back(modelLookup(vec));
    if (mPhase == 2) begin
      if (!mErr) mActive = mShadow;
      for (int i = 0; i < 26; i++) mShadow[i] = i;
      mUsed  = 0;
      mPhase = 0;
    end else if (clr) begin
      for (int i = 0; i < 26; i++) mShadow[i] = i;
      mUsed  = 0;
      mErr   = 1'b0;
      mPhase = 0;
    end else if (cv) begin
      if (mPhase == 0) mErr = 1'b0;
      ok = (a < 26) && (b < 26) && (a != b) && (mUsed < MAXP);
      if (ok) ok = (mShadow[a] == a) && (mShadow[b] == b);
      if (ok) begin
        mShadow[a] = b;
        mShadow[b] = a;
        mUsed++;
      end else begin
        mErr = 1'b1;
      end
      mPhase = last ? 2 : 1;
    end
  endtask

  task automatic sendPair(input int a, input int b, input bit last);
    applyStimulus(1'b1, a, b, last, 1'b0, 1'b0, '0);
  endtask

  task automatic lookup(input int letter);
    logic [25:0] v;
    v = 26'd1 << letter;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, v);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_last = 1'b0; cfg_clear = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    expQ.delete();
  endtask

  // Monitor: every due lookup must show out_valid with the queued result; otherwise output holds.
  always @(negedge clk) begin
    exp_t e;
    bit   haveDue;
    if (rst) begin
      lastExp = '0;
    end else begin
      haveDue = (expQ.size() > 0) && (expQ[0].due == 64'($time));
      if (out_valid && !haveDue) begin
        checks++;
        $display("[TB] FAIL out_valid: got 1 with no lookup due, expected 0 at t=%0t", $time);
      end else if (haveDue) begin
        e = expQ.pop_front();
        checkOutput("out_valid", 32'(out_valid), 32'd1);
        checkOutput("out_onehot", 32'(out_onehot), 32'(e.onehot));
`ifdef STECKER_ONEHOT_CHK_EN
        checkOutput("out_bad", 32'(out_bad), 32'(e.bad));
`endif
        lastExp = e;
      end else begin
        checkOutput("out_hold", 32'(out_onehot), 32'(lastExp.onehot));
      end
    end
  end

  initial begin
    int n;
    int a;
    int b;
    logic [25:0] v;
    modelReset();
    doReset();

    $display("[TB] identity after reset");
    lookup(0);
    idleCycle();

    $display("[TB] load A-B, E-Q and look up");
    sendPair(0, 1, 1'b0);
    sendPair(4, 16, 1'b1);
    idleCycle();
    lookup(0); lookup(1); lookup(4); lookup(16); lookup(2);
    idleCycle();

    $display("[TB] reused letter rejects the load");
    sendPair(2, 3, 1'b0);
    sendPair(3, 5, 1'b1);
    idleCycle();
    lookup(0); lookup(2); lookup(3);
    idleCycle();

    $display("[TB] pair limit overflow then clear");
    for (int p = 0; p <= MAXP; p++) sendPair(2 * p + 6, 2 * p + 7, p == MAXP);
    idleCycle();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, '0);
    idleCycle();

    $display("[TB] lookup during the commit cycle");
    sendPair(6, 7, 1'b1);
    lookup(6);
    lookup(6);
    idleCycle();

    $display("[TB] multi-hot lookup");
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 26'b11);
    idleCycle();

    $display("[TB] reset in the middle of a load");
    sendPair(8, 9, 1'b0);
    doReset();
    lookup(8); lookup(0); lookup(6);
    idleCycle();

    $display("[TB] random loads and lookups");
    for (int load = 0; load < 40; load++) begin
      n = $urandom_range(1, MAXP + 1);
      for (int p = 0; p < n; p++) begin
        if ($urandom % 4 == 0) begin
          v = 26'd1 << $urandom_range(0, 25);
          applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'($urandom), v);
        end
        a = ($urandom % 10 == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
        b = ($urandom % 10 == 0) ? a : $urandom_range(0, 25);
        v = ($urandom % 6 == 0) ? 26'($urandom) : (26'd1 << $urandom_range(0, 25));
        applyStimulus(1'b1, a, b, p == n - 1, $urandom % 25 == 0, 1'($urandom), v);
      end
      v = 26'd1 << $urandom_range(0, 25);
      applyStimulus(1'($urandom), $urandom_range(0, 25), $urandom_range(0, 25), 1'b1,
                    1'b0, 1'b1, v);
      for (int k = 0; k < 4; k++) lookup($urandom_range(0, 25));
    end

    repeat (3) idleCycle();
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
